// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and constants for the Fibonacci checker
package fib_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEED = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int FIB_W    = 16;
   localparam int FIB_SEED = 1;

endpackage

// File: rtl/fibonacci_expect.sv
// rtl/fibonacci_expect.sv - expected terms and per-lane mismatch for one beat
module fibonacci_expect #(
   parameter int W = 16
) (
   input  logic [W-1:0] h0,
   input  logic [W-1:0] h1,
   input  logic [W-1:0] in_num,
   input  logic [W-1:0] in_num2,
   input  logic         lane1_seed,
   output logic [W-1:0] e1,
   output logic [W-1:0] e2,
   output logic         mis1,
   output logic         mis2
);

   // When lane 1 completes the seed, the history after it is {h0, in_num}.
   logic [W-1:0] e2_base;

   always_comb begin
      e2_base = lane1_seed ? h0 : h1;
      e1      = h0 + h1;
      e2      = e2_base + in_num;
      mis1    = (in_num != e1);
      mis2    = (in_num2 != e2);
   end

endmodule

// File: rtl/fibonacci_checker.sv
// rtl/fibonacci_checker.sv - stream checker for modulo-2^W Fibonacci terms
module fibonacci_checker
   import fib_pkg::*;
#(
   parameter int W          = FIB_W,
   parameter int N_TERMS    = 32,
   parameter int CW         = 8,
   parameter int CHECK_SEED = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_dual,
   input  logic [W-1:0]  in_num,
   input  logic [W-1:0]  in_num2,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [CW-1:0] err_idx,
   output logic [CW-1:0] term_cnt,
   output logic [CW-1:0] err_cnt
);

   localparam logic [CW-1:0] N_CW     = CW'(N_TERMS);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_TWO  = CW'(2);
   localparam logic [CW+1:0] CNT_SAT  = {2'b00, {CW{1'b1}}};
   localparam logic [W-1:0]  SEED_VAL = W'(FIB_SEED);

   state_t        state_q, state_d;
   logic [W-1:0]  h0_q, h0_d, h1_q, h1_d;
   logic [CW-1:0] term_cnt_q, term_cnt_d;
   logic [CW-1:0] err_cnt_q, err_cnt_d;
   logic [CW-1:0] err_idx_q, err_idx_d;
   logic          err_q, err_d;
   logic          done_q, done_d;

   logic          accept, lane1_seed, lane2_seed, lane2_take;
   logic          bad1, bad2;
   logic [W-1:0]  e1, e2;
   logic          mis1, mis2;
   logic [CW-1:0] cnt_next;
   logic [CW+1:0] err_sum;

   fibonacci_expect #(.W(W)) u_expect (
      .h0         (h0_q),
      .h1         (h1_q),
      .in_num     (in_num),
      .in_num2    (in_num2),
      .lane1_seed (lane1_seed),
      .e1         (e1),
      .e2         (e2),
      .mis1       (mis1),
      .mis2       (mis2)
   );

   assign busy     = (state_q == SEED) || (state_q == RUN);
   assign in_ready = busy && !start;
   assign accept   = in_valid && in_ready;
   assign done     = done_q;
   assign err      = err_q;
   assign err_idx  = err_idx_q;
   assign term_cnt = term_cnt_q;
   assign err_cnt  = err_cnt_q;

   always_comb begin
      lane1_seed = (term_cnt_q < CNT_TWO);
      lane2_seed = (term_cnt_q == '0);
      // Lane 2 is dropped when only one term remains in the run.
      lane2_take = in_dual && ((term_cnt_q + CNT_ONE) < N_CW);
      bad1 = lane1_seed ? ((CHECK_SEED != 0) && (in_num != SEED_VAL)) : mis1;
      bad2 = lane2_take &&
             (lane2_seed ? ((CHECK_SEED != 0) && (in_num2 != SEED_VAL)) : mis2);
      cnt_next = term_cnt_q + (lane2_take ? CNT_TWO : CNT_ONE);
      err_sum  = {2'b00, err_cnt_q} + {{CW{1'b0}}, 1'b0, bad1}
                                    + {{CW{1'b0}}, 1'b0, bad2};
   end

   always_comb begin
      state_d    = state_q;
      h0_d       = h0_q;
      h1_d       = h1_q;
      term_cnt_d = term_cnt_q;
      err_cnt_d  = err_cnt_q;
      err_idx_d  = err_idx_q;
      err_d      = err_q;
      done_d     = 1'b0;

      if (start) begin
         state_d    = SEED;
         h0_d       = '0;
         h1_d       = '0;
         term_cnt_d = '0;
         err_cnt_d  = '0;
         err_idx_d  = '0;
         err_d      = 1'b0;
      end else if (accept) begin
         if (lane2_take) begin
            h0_d = in_num;
            h1_d = in_num2;
         end else if (term_cnt_q == '0) begin
            h0_d = in_num;
         end else if (term_cnt_q == CNT_ONE) begin
            h1_d = in_num;
         end else begin
            h0_d = h1_q;
            h1_d = in_num;
         end

         term_cnt_d = cnt_next;
         err_cnt_d  = (err_sum > CNT_SAT) ? {CW{1'b1}} : err_sum[CW-1:0];
         err_d      = err_q || bad1 || bad2;
         if (!err_q) begin
            if (bad1) begin
               err_idx_d = term_cnt_q;
            end else if (bad2) begin
               err_idx_d = term_cnt_q + CNT_ONE;
            end
         end

         if (cnt_next == N_CW) begin
            state_d = DONE;
            done_d  = 1'b1;
         end else if (cnt_next >= CNT_TWO) begin
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         h0_q       <= '0;
         h1_q       <= '0;
         term_cnt_q <= '0;
         err_cnt_q  <= '0;
         err_idx_q  <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         h0_q       <= h0_d;
         h1_q       <= h1_d;
         term_cnt_q <= term_cnt_d;
         err_cnt_q  <= err_cnt_d;
         err_idx_q  <= err_idx_d;
         err_q      <= err_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_fibonacci_checker.sv
// tb/tb_fibonacci_checker.sv - randomized check of fibonacci_checker against a term-list model
module tb_fibonacci_checker;

   localparam int N = 26;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_dual = 1'b0;
   logic [15:0] in_num = '0;
   logic [15:0] in_num2 = '0;

   logic       a_in_ready, a_busy, a_done, a_err;
   logic [7:0] a_err_idx, a_term_cnt, a_err_cnt;
   logic       b_in_ready, b_busy, b_done, b_err;
   logic [7:0] b_err_idx, b_term_cnt, b_err_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: the list of accepted terms; every check is derived from it.
   int unsigned mt[$];
   bit          m_busy = 0;
   bit          m_done = 0;
   bit          m_err[2];
   int          m_idx[2];
   int          m_cnt[2];

   always #5 clk = ~clk;

   fibonacci_checker #(.W(16), .N_TERMS(N), .CW(8), .CHECK_SEED(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(a_in_ready), .in_dual(in_dual), .in_num(in_num), .in_num2(in_num2),
      .busy(a_busy), .done(a_done), .err(a_err), .err_idx(a_err_idx),
      .term_cnt(a_term_cnt), .err_cnt(a_err_cnt)
   );

   fibonacci_checker #(.W(16), .N_TERMS(N), .CW(8), .CHECK_SEED(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(b_in_ready), .in_dual(in_dual), .in_num(in_num), .in_num2(in_num2),
      .busy(b_busy), .done(b_done), .err(b_err), .err_idx(b_err_idx),
      .term_cnt(b_term_cnt), .err_cnt(b_err_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit term_bad(input int k, input bit check_seed);
      if (k < 2) return check_seed && (mt[k] != 1);
      return mt[k] != ((mt[k-1] + mt[k-2]) & 32'hffff);
   endfunction

   task automatic model_clear();
      mt.delete();
      m_done = 0;
      for (int j = 0; j < 2; j++) begin
         m_err[j] = 0;
         m_idx[j] = 0;
         m_cnt[j] = 0;
      end
   endtask

   task automatic model_push(input int unsigned v);
      int k;
      mt.push_back(v);
      k = mt.size() - 1;
      for (int j = 0; j < 2; j++) begin
         if (term_bad(k, j == 0)) begin
            if (!m_err[j]) begin
               m_err[j] = 1;
               m_idx[j] = k;
            end
            if (m_cnt[j] < 255) m_cnt[j]++;
         end
      end
   endtask

   function automatic logic [15:0] good1();
      if (mt.size() < 2) return 16'd1;
      return 16'(mt[mt.size()-1] + mt[mt.size()-2]);
   endfunction

   function automatic logic [15:0] good2(input logic [15:0] a);
      if (mt.size() == 0) return 16'd1;
      if (mt.size() == 1) return 16'(mt[0] + a);
      return 16'(mt[mt.size()-1] + a);
   endfunction

   task automatic check_outputs();
      check_eq("busy_a", a_busy, m_busy);
      check_eq("busy_b", b_busy, m_busy);
      check_eq("done_a", a_done, m_done);
      check_eq("done_b", b_done, m_done);
      check_eq("term_cnt_a", a_term_cnt, mt.size());
      check_eq("term_cnt_b", b_term_cnt, mt.size());
      check_eq("err_a", a_err, m_err[0]);
      check_eq("err_b", b_err, m_err[1]);
      check_eq("err_idx_a", a_err_idx, m_idx[0]);
      check_eq("err_idx_b", b_err_idx, m_idx[1]);
      check_eq("err_cnt_a", a_err_cnt, m_cnt[0]);
      check_eq("err_cnt_b", b_err_cnt, m_cnt[1]);
   endtask

   task automatic beat(input bit s, input bit v, input bit d,
                       input logic [15:0] a, input logic [15:0] b);
      bit rdy, acc;
      @(negedge clk);
      check_outputs();
      start = s; in_valid = v; in_dual = d; in_num = a; in_num2 = b;
      #1;
      rdy = m_busy && !s;
      check_eq("in_ready_a", a_in_ready, rdy);
      check_eq("in_ready_b", b_in_ready, rdy);
      acc = v && rdy;
      @(posedge clk);
      m_done = 0;
      if (s) begin
         model_clear();
         m_busy = 1;
      end else if (acc) begin
         model_push(a);
         if (d && mt.size() < N) model_push(b);
         if (mt.size() == N) begin
            m_busy = 0;
            m_done = 1;
         end
      end
   endtask

   task automatic idle();
      beat(0, 0, 0, 16'd0, 16'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; start = 0; in_valid = 0; in_dual = 0;
      model_clear();
      m_busy = 0;
      #1;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic singles(input int unsigned vals[$]);
      foreach (vals[i]) beat(0, 1, 0, 16'(vals[i]), 16'd0);
   endtask

   task automatic good_run(input int budget);
      logic [15:0] a;
      for (int i = 0; i < budget && m_busy; i++) begin
         a = good1();
         beat(0, ($urandom % 4) != 0, 1'($urandom), a, good2(a));
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle();

      // Clean stream through the 16-bit wrap, mixed single/dual with gaps.
      beat(1, 0, 0, 0, 0);
      good_run(120);
      idle();
      check_eq("wrap_busy_a", a_busy, 0);
      check_eq("wrap_cnt_a", a_term_cnt, N);
      check_eq("wrap_err_a", a_err, 0);
      idle();

      // Valid held during start, then dual beats with gaps.
      beat(1, 1, 1, 16'd1, 16'd1);
      beat(0, 1, 1, 16'd1, 16'd1);
      idle();
      beat(0, 1, 1, 16'd2, 16'd3);
      idle();
      beat(0, 1, 1, 16'd5, 16'd8);
      idle();
      check_eq("dual_cnt_a", a_term_cnt, 6);
      check_eq("dual_err_a", a_err, 0);

      // Corrupted term resyncs through history.
      beat(1, 0, 0, 0, 0);
      singles('{1, 1, 2, 4, 6, 10});
      idle();
      check_eq("resync_idx_a", a_err_idx, 3);
      check_eq("resync_cnt_a", a_err_cnt, 1);

      // Seed checking vs free seed.
      beat(1, 0, 0, 0, 0);
      singles('{1, 2, 3});
      idle();
      check_eq("seed_idx_a", a_err_idx, 1);
      check_eq("seed_cnt_a", a_err_cnt, 1);
      check_eq("seed_err_b", b_err, 0);
      beat(1, 0, 0, 0, 0);
      singles('{2, 3, 5});
      idle();
      check_eq("free_seed_err_b", b_err, 0);
      check_eq("free_seed_cnt_a", a_err_cnt, 2);

      // Reset mid-run, then restart from RUN with err set.
      beat(1, 0, 0, 0, 0);
      singles('{1, 1, 2});
      do_reset();
      idle();
      check_eq("rst_busy_a", a_busy, 0);
      beat(1, 0, 0, 0, 0);
      singles('{1, 3, 4});
      beat(1, 1, 0, 16'd7, 16'd0);
      idle();
      check_eq("restart_err_a", a_err, 0);
      check_eq("restart_cnt_a", a_term_cnt, 0);
      check_eq("restart_busy_a", a_busy, 1);

      // Randomized runs with occasional corruption, restarts and resets.
      for (int r = 0; r < 30; r++) begin
         beat(1, 1'($urandom), 0, 16'd1, 16'd1);
         for (int i = 0; i < 70 && m_busy; i++) begin
            logic [15:0] a, b;
            a = (($urandom % 8) == 0) ? 16'($urandom) : good1();
            b = (($urandom % 8) == 0) ? 16'($urandom) : good2(a);
            beat(($urandom % 50) == 0, ($urandom % 4) != 0, 1'($urandom), a, b);
         end
         idle();
         if (($urandom % 8) == 0) do_reset();
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
